// File: rtl/i2c_slave_responder_if.sv
// I2C target bus bundle: sampled SCL/SDA levels, open-drain SDA
// enable, and the byte-level write/read side of the responder.
interface i2c_slave_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       addressed;
  logic       busy;

  modport slave (
    input  scl_i,
    input  sda_i,
    input  rd_data,
    output sda_oe,
    output wr_valid,
    output wr_data,
    output rd_req,
    output addressed,
    output busy
  );

  modport master (
    output scl_i,
    output sda_i,
    output rd_data,
    input  sda_oe,
    input  wr_valid,
    input  wr_data,
    input  rd_req,
    input  addressed,
    input  busy
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// Oversampling I2C target: START/STOP detect, 7-bit address match,
// write bytes out on a byte port, read bytes fetched on request.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic areset,
  i2c_slave_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] scl_sync;
  logic [NS-1:0] sda_sync;
  logic          scl_d;
  logic          sda_d;
  logic          scl_s;
  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;

  state_t     state;
  logic [2:0] cnt;
  logic [6:0] shreg;
  logic       rw;
  logic       pend;
  logic       sda_oe_q;
  logic       wr_valid_q;
  logic [7:0] wr_data_q;
  logic       rd_req_q;
  logic       addressed_q;
  logic       busy_q;

  assign scl_s = scl_sync[NS-1];
  assign sda_s = sda_sync[NS-1];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.addressed = addressed_q;
  assign bus.busy      = busy_q;

  // Idle-high bus: load 1s so reset release never looks like an edge
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NS-2:0], bus.scl_i};
      sda_sync <= {sda_sync[NS-2:0], bus.sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      shreg       <= 7'd0;
      rw          <= 1'b0;
      pend        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= 8'h00;
      rd_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (start_det) begin
        state       <= ADDR;
        busy_q      <= 1'b1;
        addressed_q <= 1'b0;
        cnt         <= 3'd0;
        pend        <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (stop_det) begin
        state       <= IDLE;
        busy_q      <= 1'b0;
        addressed_q <= 1'b0;
        cnt         <= 3'd0;
        pend        <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            sda_oe_q <= 1'b0;
          end
          ADDR: begin
            if (scl_rise && !pend) begin
              shreg <= {shreg[5:0], sda_s};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (shreg == SLAVE_ADDR) begin
                  pend <= 1'b1;
                  rw   <= sda_s;
                end else begin
                  state <= IGNORE;
                end
              end
            end else if (scl_fall && pend) begin
              pend        <= 1'b0;
              sda_oe_q    <= 1'b1;
              addressed_q <= 1'b1;
              rd_req_q    <= rw;
              state       <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 3'd0;
              if (rw) begin
                shreg    <= bus.rd_data[6:0];
                sda_oe_q <= ~bus.rd_data[7];
                state    <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state    <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && !pend) begin
              shreg <= {shreg[5:0], sda_s};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                wr_valid_q <= 1'b1;
                wr_data_q  <= {shreg, sda_s};
                pend       <= 1'b1;
              end
            end else if (scl_fall && pend) begin
              pend     <= 1'b0;
              sda_oe_q <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt      <= 3'd0;
              state    <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (cnt == 3'd7) begin
                sda_oe_q <= 1'b0;
                cnt      <= 3'd0;
                state    <= RD_ACK;
              end else begin
                sda_oe_q <= ~shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
                cnt      <= cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !pend) begin
              if (!sda_s) begin
                rd_req_q <= 1'b1;
                pend     <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && pend) begin
              pend     <= 1'b0;
              shreg    <= bus.rd_data[6:0];
              sda_oe_q <= ~bus.rd_data[7];
              cnt      <= 3'd0;
              state    <= RD_DATA;
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master with
// scoreboard queues for write bytes and read bytes.
module tb_i2c_slave_responder;
  localparam int Q = 10;

  logic pclk   = 1'b0;
  logic areset = 1'b0;
  logic m_scl  = 1'b1;
  logic m_sda  = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic sda_bus;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;

  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_src[$];

  i2c_slave_responder_if bus();

  assign sda_bus     = m_sda & ~bus.sda_oe;
  assign bus.scl_i   = m_scl;
  assign bus.sda_i   = sda_bus;
  assign bus.rd_data = rd_byte;

  i2c_slave_responder #(
    .SLAVE_ADDR (7'h68),
    .SYNC_STAGES(2)
  ) dut (
    .pclk  (pclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge pclk) begin
    if (bus.sda_oe) oe_cnt++;
    if (bus.wr_valid) begin
      wr_cnt++;
      if (exp_wr.size() > 0) chk("wr_data", bus.wr_data, exp_wr.pop_front());
    end
    if (bus.rd_req) begin
      rd_cnt++;
      rd_byte = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
    end
  end

  task automatic q();
    repeat (Q) @(negedge pclk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = sda_bus; q();
    m_scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    int w0, r0, o0;

    repeat (5) @(negedge pclk);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_addressed", bus.addressed, 0);
    chk("rst_busy", bus.busy, 0);
    areset = 1'b1;
    q();

    // write 0x68/W, A5, 3C
    w0 = wr_cnt;
    exp_wr.push_back(8'hA5);
    exp_wr.push_back(8'h3C);
    i2c_start();
    chk("t1_busy", bus.busy, 1);
    write_byte(8'hD0, ack);
    chk("t1_addr_ack", ack, 0);
    chk("t1_addressed", bus.addressed, 1);
    write_byte(8'hA5, ack);
    chk("t1_ack_a5", ack, 0);
    write_byte(8'h3C, ack);
    chk("t1_ack_3c", ack, 0);
    i2c_stop();
    q();
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_addr_end", bus.addressed, 0);
    chk("t1_wr_cnt", wr_cnt - w0, 2);
    chk("t1_wr_hold", bus.wr_data, 8'h3C);

    // wrong address
    w0 = wr_cnt;
    o0 = oe_cnt;
    i2c_start();
    write_byte(8'h42, ack);
    chk("t2_addr_nack", ack, 1);
    chk("t2_addressed", bus.addressed, 0);
    write_byte(8'h55, ack);
    chk("t2_data_nack", ack, 1);
    i2c_stop();
    q();
    chk("t2_oe_cycles", oe_cnt - o0, 0);
    chk("t2_wr_cnt", wr_cnt - w0, 0);
    chk("t2_busy", bus.busy, 0);

    // read two bytes, ACK then NACK
    r0 = rd_cnt;
    rd_src.push_back(8'h5A);
    rd_src.push_back(8'hC3);
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hC3);
    i2c_start();
    write_byte(8'hD1, ack);
    chk("t3_addr_ack", ack, 0);
    read_byte(rb);
    chk("t3_rd0", rb, exp_rd.pop_front());
    write_bit(1'b0);
    read_byte(rb);
    chk("t3_rd1", rb, exp_rd.pop_front());
    write_bit(1'b1);
    q();
    chk("t3_oe_after_nack", bus.sda_oe, 0);
    chk("t3_rd_req_cnt", rd_cnt - r0, 2);
    i2c_stop();
    q();
    chk("t3_busy", bus.busy, 0);

    // write then repeated START into read
    w0 = wr_cnt;
    r0 = rd_cnt;
    exp_wr.push_back(8'h11);
    rd_src.push_back(8'hF0);
    exp_rd.push_back(8'hF0);
    i2c_start();
    write_byte(8'hD0, ack);
    chk("t4_addr_ack", ack, 0);
    write_byte(8'h11, ack);
    chk("t4_ack_11", ack, 0);
    i2c_rstart();
    chk("t4_busy_rs", bus.busy, 1);
    chk("t4_addr_rs", bus.addressed, 0);
    write_byte(8'hD1, ack);
    chk("t4_raddr_ack", ack, 0);
    read_byte(rb);
    chk("t4_rd", rb, exp_rd.pop_front());
    write_bit(1'b1);
    i2c_stop();
    q();
    chk("t4_wr_cnt", wr_cnt - w0, 1);
    chk("t4_rd_req_cnt", rd_cnt - r0, 1);

    // STOP after 4 data bits
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hD0, ack);
    chk("t5_addr_ack", ack, 0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    q();
    chk("t5_wr_cnt", wr_cnt - w0, 0);
    chk("t5_sda_oe", bus.sda_oe, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_addressed", bus.addressed, 0);

    // reset while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 6 || i == 4);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    chk("t6_oe_pre", bus.sda_oe, 1);
    #2 areset = 1'b0;
    #1;
    chk("t6_oe_async", bus.sda_oe, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_addressed", bus.addressed, 0);
    chk("t6_wr_data", bus.wr_data, 0);
    m_scl = 1'b0; q();
    m_scl = 1'b1; q();
    areset = 1'b1;
    q();
    w0 = wr_cnt;
    exp_wr.push_back(8'h77);
    i2c_start();
    write_byte(8'hD0, ack);
    chk("t6_addr_ack", ack, 0);
    write_byte(8'h77, ack);
    chk("t6_ack_77", ack, 0);
    i2c_stop();
    q();
    chk("t6_wr_cnt", wr_cnt - w0, 1);
    chk("t6_busy_end", bus.busy, 0);
    chk("sb_wr_empty", exp_wr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) that answers the master driver on the shared open-drain SCL/SDA bus.
- Oversamples SCL/SDA on the system clock, detects START and STOP, and matches a 7-bit address.
- Acknowledges the address, delivers written bytes on a byte port, and fetches read bytes from a byte port.
- Sits in hdl_top as the DUT-side responder that the master BFM drives against.

Parameters:
- SLAVE_ADDR, 7'h68, 7-bit address this target answers.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (minimum 2).

Ports:
- pclk  input  1  system clock; must be at least 8x the SCL rate.
- areset  input  1  asynchronous, active-low reset.
- scl_i  input  1  bus SCL level.
- sda_i  input  1  bus SDA level.
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain).
- wr_valid  output  1  one-cycle pulse: wr_data holds a received write byte.
- wr_data  output  8  received write byte; holds its value until the next wr_valid.
- rd_req  output  1  one-cycle pulse: next read byte is requested.
- rd_data  input  8  read byte; must be valid within 2 pclk cycles after rd_req.
- addressed  output  1  high from address ACK until STOP or repeated START.
- busy  output  1  high from START until STOP.

Behaviour:
- Clock and reset: one clock, pclk. Reset is areset, asynchronous, active-low.
- Reset values: sda_oe=0, wr_valid=0, wr_data=8'h00, rd_req=0, addressed=0, busy=0. State is IDLE and the synchronizers are loaded with 1.
- Reset mid-transfer releases SDA immediately. Reset has priority over every other event.
- Synchronization: scl_i and sda_i pass through SYNC_STAGES flops. Edges are detected on the synchronized values, giving scl_rise and scl_fall pulses.
- START: synchronized SDA 1->0 while synchronized SCL=1.
- STOP: synchronized SDA 0->1 while synchronized SCL=1.
- START and STOP override any state, including mid-bit and mid-ACK. sda_oe drops to 0 the same cycle.
- START (including repeated START) goes to ADDR, sets busy=1, clears addressed and the bit counter.
- STOP goes to IDLE, clears busy and addressed.
- Data bits are sampled on scl_rise, MSB first, by a 3-bit counter counting 0..7.
- sda_oe changes only on the cycle after scl_fall, so SDA is stable while SCL is high.
- IDLE: wait for START.
- ADDR:
  - Shift in 8 bits (addr[6:0], rw).
  - On the 8th scl_rise, compare addr to SLAVE_ADDR.
  - Mismatch: go to IGNORE; sda_oe stays 0.
  - Match: on the next scl_fall, assert sda_oe=1, set addressed=1, and go to ADDR_ACK.
  - If rw=1, rd_req pulses on that same cycle.
- ADDR_ACK: sda_oe held through the ACK SCL-high period. On the scl_fall ending the ACK:
  - rw=0: release SDA and go to WR_DATA.
  - rw=1: load the shift register from rd_data, drive bit7 (sda_oe = ~bit), go to RD_DATA.
- WR_DATA:
  - Shift 8 bits.
  - On the 8th scl_rise, pulse wr_valid with wr_data = the assembled byte.
  - On the next scl_fall, assert sda_oe=1 and go to WR_ACK.
  - Every write byte is ACKed.
- WR_ACK: on the scl_fall ending the ACK, release SDA and go to WR_DATA.
- RD_DATA:
  - On each scl_fall, drive the next bit with sda_oe = ~bit.
  - After the 8th bit's scl_fall, release SDA (sda_oe=0) and go to RD_ACK.
- RD_ACK: sample the master's ACK on scl_rise.
  - ACK (0): pulse rd_req and stay in RD_ACK. On the following scl_fall, load rd_data, drive bit7, and go to RD_DATA.
  - NACK (1): go to IGNORE.
- IGNORE: sda_oe=0 and outputs idle; leave only on START or STOP.
- Bus contention is not detected. While driving a 1, the target releases SDA and does not check the level.
- SCL stretching is not supported; SCL is never driven.
- Back-to-back bytes: the bit counter wraps from 7 to 0 with no idle cycles required.

Test Plan:
- Write 0x68/W, then 0xA5, 0x3C, then STOP -> ACK on all 3 bytes. wr_valid pulses twice with 0xA5 then 0x3C. addressed=1 during transfer. busy and addressed = 0 after STOP.
- Address 0x21/W -> no ACK (sda_oe=0 throughout). No wr_valid. addressed=0. Target returns to IDLE on STOP.
- Read 0x68/R, rd_data=0x5A then 0xC3, master ACKs byte 1 and NACKs byte 2 -> SDA carries 01011010 then 11000011. rd_req pulses exactly twice. sda_oe=0 after the NACK.
- Write 0x68/W, 0x11, then repeated START, then 0x68/R with rd_data=0xF0 -> wr_valid with 0x11, then read returns 0xF0. busy stays 1 across the repeated START.
- STOP injected after 4 bits of a write byte -> no wr_valid. sda_oe=0. State IDLE. busy=0.
- areset asserted while the target drives ACK (sda_oe=1) -> sda_oe=0 asynchronously and all outputs take their reset values. A fresh 0x68/W transaction then ACKs normally.
